// File: rtl/ew_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ew_pkg
//  Description : Shared types and default timing constants for channel hopping.
//  Revision    : 1.0 - initial release
// ============================================================================
package ew_pkg;

    typedef logic [1:0] channel_t;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        QUALIFY = 2'd1,
        REQUEST = 2'd2,
        DWELL   = 2'd3
    } hop_state_t;

    localparam int c_DEF_STABLE_CYCLES = 4;
    localparam int c_DEF_MIN_DWELL     = 16;
    localparam int c_DEF_ACK_TIMEOUT   = 8;

endpackage
`default_nettype wire

// File: rtl/terminal_counter.sv
`default_nettype none
// ============================================================================
//  Module      : terminal_counter
//  Description : 8-bit up counter with clear, enable and terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module terminal_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_terminal,
    output logic       o_tc
);

    logic [7:0] r_count;

    // Clear wins over enable so a new interval always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_tc = (r_count == i_terminal);

endmodule
`default_nettype wire

// File: rtl/channel_hop_controller.sv
`default_nettype none
// ============================================================================
//  Module      : channel_hop_controller
//  Description : Debounces the safest-channel report and runs a hop handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_hop_controller
    import ew_pkg::*;
#(
    parameter int STABLE_CYCLES = c_DEF_STABLE_CYCLES,
    parameter int MIN_DWELL     = c_DEF_MIN_DWELL,
    parameter int ACK_TIMEOUT   = c_DEF_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] safest_channel,
    input  logic       hop_ack,
    output logic       hop_req,
    output logic [1:0] hop_target,
    output logic [1:0] active_channel,
    output logic [7:0] hop_count,
    output logic       hop_fail
);

    generate
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 ||
            MIN_DWELL     < 1 || MIN_DWELL     > 255 ||
            ACK_TIMEOUT   < 1 || ACK_TIMEOUT   > 255) begin : g_param_check
            $error("channel_hop_controller: parameters must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] c_STABLE_LAST  = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] c_DWELL_LAST   = 8'(MIN_DWELL - 1);

    hop_state_t r_state, w_state_nxt;
    channel_t   r_candidate, w_candidate_nxt;
    logic [7:0] r_stable_cnt, w_stable_cnt_nxt;
    logic       r_hop_req, w_hop_req_nxt;
    channel_t   r_hop_target, w_hop_target_nxt;
    channel_t   r_active, w_active_nxt;
    logic [7:0] r_hop_count, w_hop_count_nxt;
    logic       r_hop_fail, w_hop_fail_nxt;
    logic       w_tc;

    // One timer serves both the ack timeout and the dwell interval.
    terminal_counter u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_state_nxt != r_state),
        .i_enable   (r_state == REQUEST || r_state == DWELL),
        .i_terminal ((r_state == REQUEST) ? c_TIMEOUT_LAST : c_DWELL_LAST),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= MONITOR;
            r_candidate  <= 2'd0;
            r_stable_cnt <= 8'd0;
            r_hop_req    <= 1'b0;
            r_hop_target <= 2'd0;
            r_active     <= 2'd0;
            r_hop_count  <= 8'd0;
            r_hop_fail   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_candidate  <= w_candidate_nxt;
            r_stable_cnt <= w_stable_cnt_nxt;
            r_hop_req    <= w_hop_req_nxt;
            r_hop_target <= w_hop_target_nxt;
            r_active     <= w_active_nxt;
            r_hop_count  <= w_hop_count_nxt;
            r_hop_fail   <= w_hop_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MONITOR: if (safest_channel != r_active)
                         w_state_nxt = (STABLE_CYCLES == 1) ? REQUEST : QUALIFY;
            QUALIFY: begin
                if (safest_channel == r_candidate) begin
                    if (r_stable_cnt == c_STABLE_LAST) w_state_nxt = REQUEST;
                end else if (safest_channel == r_active) begin
                    w_state_nxt = MONITOR;
                end
            end
            REQUEST: if (hop_ack || w_tc) w_state_nxt = DWELL;
            DWELL:   if (w_tc) w_state_nxt = MONITOR;
            default: w_state_nxt = MONITOR;
        endcase
    end

    always_comb begin
        w_candidate_nxt  = r_candidate;
        w_stable_cnt_nxt = r_stable_cnt;
        w_hop_req_nxt    = r_hop_req;
        w_hop_target_nxt = r_hop_target;
        w_active_nxt     = r_active;
        w_hop_count_nxt  = r_hop_count;
        w_hop_fail_nxt   = 1'b0;
        case (r_state)
            MONITOR: begin
                if (safest_channel != r_active) begin
                    w_candidate_nxt  = safest_channel;
                    w_stable_cnt_nxt = 8'd1;
                    if (STABLE_CYCLES == 1) begin
                        w_hop_req_nxt    = 1'b1;
                        w_hop_target_nxt = safest_channel;
                    end
                end
            end
            QUALIFY: begin
                if (safest_channel == r_candidate) begin
                    if (r_stable_cnt == c_STABLE_LAST) begin
                        w_hop_req_nxt    = 1'b1;
                        w_hop_target_nxt = r_candidate;
                    end else begin
                        w_stable_cnt_nxt = r_stable_cnt + 8'd1;
                    end
                end else if (safest_channel != r_active) begin
                    w_candidate_nxt  = safest_channel;
                    w_stable_cnt_nxt = 8'd1;
                end
            end
            REQUEST: begin
                // An ack on the expiry cycle still counts as success.
                if (hop_ack) begin
                    w_active_nxt    = r_hop_target;
                    w_hop_count_nxt = (r_hop_count == 8'hFF) ? r_hop_count
                                                             : r_hop_count + 8'd1;
                    w_hop_req_nxt   = 1'b0;
                end else if (w_tc) begin
                    w_hop_req_nxt  = 1'b0;
                    w_hop_fail_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign hop_req        = r_hop_req;
    assign hop_target     = r_hop_target;
    assign active_channel = r_active;
    assign hop_count      = r_hop_count;
    assign hop_fail       = r_hop_fail;

endmodule
`default_nettype wire

// File: tb/tb_channel_hop_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_hop_controller
//  Description : Self-checking bench with a run-length behavioural hop model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_hop_controller;

    localparam int c_STABLE  = 4;
    localparam int c_DWELL   = 16;
    localparam int c_TIMEOUT = 8;

    localparam int c_PH_WATCH = 0;
    localparam int c_PH_REQ   = 1;
    localparam int c_PH_DWELL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] safest_channel = 2'd0;
    logic       hop_ack = 1'b0;
    logic       hop_req;
    logic [1:0] hop_target;
    logic [1:0] active_channel;
    logic [7:0] hop_count;
    logic       hop_fail;

    int checks = 0;
    int errors = 0;

    channel_hop_controller #(
        .STABLE_CYCLES (c_STABLE),
        .MIN_DWELL     (c_DWELL),
        .ACK_TIMEOUT   (c_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .safest_channel (safest_channel),
        .hop_ack        (hop_ack),
        .hop_req        (hop_req),
        .hop_target     (hop_target),
        .active_channel (active_channel),
        .hop_count      (hop_count),
        .hop_fail       (hop_fail)
    );

    initial forever #5 clk = ~clk;

    // Behavioural model: a hop is requested once the trailing run of identical
    // samples since watching began reaches c_STABLE and differs from active.
    int         phase = c_PH_WATCH;
    int         run = 0;
    int         waited = 0;
    int         dwell_left = 0;
    logic [1:0] last = 2'd0;
    logic       m_req = 1'b0;
    logic [1:0] m_target = 2'd0;
    logic [1:0] m_active = 2'd0;
    logic [7:0] m_count = 8'd0;
    logic       m_fail = 1'b0;

    task automatic model_step();
        if (reset) begin
            phase = c_PH_WATCH; run = 0; waited = 0; dwell_left = 0; last = 2'd0;
            m_req = 1'b0; m_target = 2'd0; m_active = 2'd0; m_count = 8'd0; m_fail = 1'b0;
            return;
        end
        m_fail = 1'b0;
        if (phase == c_PH_WATCH) begin
            if (run > 0 && safest_channel == last) run++;
            else begin last = safest_channel; run = 1; end
            if (last != m_active && run >= c_STABLE) begin
                phase = c_PH_REQ; m_req = 1'b1; m_target = last; waited = 0;
            end
        end else if (phase == c_PH_REQ) begin
            waited++;
            if (hop_ack) begin
                m_active = m_target;
                if (m_count != 8'd255) m_count = m_count + 8'd1;
                m_req = 1'b0; phase = c_PH_DWELL; dwell_left = c_DWELL;
            end else if (waited == c_TIMEOUT) begin
                m_req = 1'b0; m_fail = 1'b1; phase = c_PH_DWELL; dwell_left = c_DWELL;
            end
        end else begin
            dwell_left--;
            if (dwell_left == 0) begin phase = c_PH_WATCH; run = 0; end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        checks++;
        if ({hop_req, hop_target, active_channel, hop_count, hop_fail} !==
            {m_req, m_target, m_active, m_count, m_fail}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got req=%0b tgt=%0d act=%0d cnt=%0d fail=%0b, want req=%0b tgt=%0d act=%0d cnt=%0d fail=%0b",
                     $time, hop_req, hop_target, active_channel, hop_count, hop_fail,
                     m_req, m_target, m_active, m_count, m_fail);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] sa, input logic ack);
        @(negedge clk);
        safest_channel = sa;
        hop_ack = ack;
        @(posedge clk);
        #2;
    endtask

    logic [1:0] ch;
    logic [1:0] cur;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_req", hop_req, 0);
        check("reset_active", active_channel, 0);
        check("reset_count", hop_count, 0);
        @(negedge clk) reset = 1'b0;

        // Glitch: three samples of 1 then back to active 0.
        repeat (3) step(2'd1, 1'b0);
        step(2'd0, 1'b0);
        step(2'd0, 1'b0);
        check("glitch_no_req", hop_req, 0);

        // Stability: four samples of 2 request channel 2.
        repeat (3) step(2'd2, 1'b0);
        check("stable_req_early", hop_req, 0);
        step(2'd2, 1'b0);
        check("stable_req", hop_req, 1);
        check("stable_target", hop_target, 2);
        step(2'd2, 1'b1);
        check("ack_active", active_channel, 2);
        check("ack_count", hop_count, 1);
        check("ack_req_drop", hop_req, 0);

        // Dwell ignores safest_channel for exactly c_DWELL cycles.
        repeat (c_DWELL) step(2'd3, 1'b0);
        check("dwell_no_req", hop_req, 0);
        repeat (3) step(2'd3, 1'b0);
        check("post_dwell_req_early", hop_req, 0);
        step(2'd3, 1'b0);
        check("post_dwell_req", hop_req, 1);
        check("post_dwell_target", hop_target, 3);

        // Timeout: no ack for c_TIMEOUT cycles.
        repeat (c_TIMEOUT - 1) step(2'd3, 1'b0);
        check("timeout_fail_early", hop_fail, 0);
        check("timeout_req_held", hop_req, 1);
        step(2'd3, 1'b0);
        check("timeout_fail", hop_fail, 1);
        check("timeout_req_drop", hop_req, 0);
        check("timeout_active", active_channel, 2);
        step(2'd1, 1'b1);
        check("timeout_fail_pulse", hop_fail, 0);
        repeat (c_DWELL - 1) step(2'd1, 1'b1);
        check("dwell_ack_ignored_active", active_channel, 2);
        check("dwell_ack_ignored_count", hop_count, 1);

        // Candidate switch: 1,1,3,3,3,3 gives one request for 3.
        step(2'd1, 1'b0); step(2'd1, 1'b0);
        repeat (3) step(2'd3, 1'b0);
        check("switch_req_early", hop_req, 0);
        step(2'd3, 1'b0);
        check("switch_req", hop_req, 1);
        check("switch_target", hop_target, 3);

        // Ack arriving on the expiry cycle wins.
        repeat (c_TIMEOUT - 1) step(2'd3, 1'b0);
        step(2'd3, 1'b1);
        check("edge_ack_active", active_channel, 3);
        check("edge_ack_count", hop_count, 2);
        check("edge_ack_fail", hop_fail, 0);
        step(2'd1, 1'b0);
        check("edge_ack_fail_next", hop_fail, 0);
        repeat (c_DWELL - 1) step(2'd1, 1'b0);

        // Asynchronous reset mid-request.
        repeat (c_STABLE) step(2'd1, 1'b0);
        check("pre_reset_req", hop_req, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_req", hop_req, 0);
        check("async_reset_target", hop_target, 0);
        check("async_reset_active", active_channel, 0);
        check("async_reset_count", hop_count, 0);
        check("async_reset_fail", hop_fail, 0);
        @(posedge clk);
        #2;
        @(negedge clk) reset = 1'b0;

        // Saturation: 256 successful hops.
        ch = 2'd0;
        for (int i = 0; i < 256; i++) begin
            ch = ch + 2'd1;
            repeat (c_STABLE) step(ch, 1'b0);
            step(ch, 1'b1);
            repeat (c_DWELL) step(ch, 1'b0);
            if (i == 254) check("count_255", hop_count, 255);
        end
        check("count_saturated", hop_count, 255);

        // Randomized traffic with occasional resets.
        cur = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #2;
                @(negedge clk) reset = 1'b0;
            end
            step(cur, ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
